// File: rtl/rob_branch_chkpt_ctrl_if.sv
// Bundle of the dispatch, execute, commit and ROB-facing signals of the
// branch-checkpoint controller.
//   master : environment side (dispatch, execute, retire and ROB models)
//   slave  : the controller itself
// Signal names follow the ROB/pipeline port names they connect to.
interface rob_branch_chkpt_ctrl_if #(
    parameter int DEPTH = 16,
    parameter int NCHK  = 4
);
    localparam int RW = $clog2(DEPTH);
    localparam int CW = $clog2(NCHK);

    logic          disp_valid_i;
    logic          disp_is_branch_i;
    logic          disp_ready_o;
    logic          rob_alloc_valid_o;
    logic          rob_alloc_ready_i;
    logic [RW-1:0] rob_chkpt_tail_i;
    logic [RW:0]   rob_chkpt_used_i;
    logic          mp_valid_i;
    logic [RW-1:0] mp_rob_index_i;
    logic [31:0]   mp_target_i;
    logic          mp_ready_o;
    logic          commit_valid_i;
    logic          commit_is_branch_i;
    logic          commit_ready_i;
    logic          rob_commit_ready_o;
    logic          rob_recover_o;
    logic [RW-1:0] rob_recover_tail_o;
    logic [RW:0]   rob_recover_used_o;
    logic          redirect_valid_o;
    logic [31:0]   redirect_pc_o;
    logic [CW:0]   chk_free_o;
    logic          err_nomatch_o;

    modport master (
        output disp_valid_i, disp_is_branch_i, rob_alloc_ready_i, rob_chkpt_tail_i,
               rob_chkpt_used_i, mp_valid_i, mp_rob_index_i, mp_target_i,
               commit_valid_i, commit_is_branch_i, commit_ready_i,
        input  disp_ready_o, rob_alloc_valid_o, mp_ready_o, rob_commit_ready_o,
               rob_recover_o, rob_recover_tail_o, rob_recover_used_o,
               redirect_valid_o, redirect_pc_o, chk_free_o, err_nomatch_o
    );

    modport slave (
        input  disp_valid_i, disp_is_branch_i, rob_alloc_ready_i, rob_chkpt_tail_i,
               rob_chkpt_used_i, mp_valid_i, mp_rob_index_i, mp_target_i,
               commit_valid_i, commit_is_branch_i, commit_ready_i,
        output disp_ready_o, rob_alloc_valid_o, mp_ready_o, rob_commit_ready_o,
               rob_recover_o, rob_recover_tail_o, rob_recover_used_o,
               redirect_valid_o, redirect_pc_o, chk_free_o, err_nomatch_o
    );
endinterface

// File: rtl/rob_branch_chkpt_ctrl.sv
// Branch-checkpoint controller between dispatch/execute and the ROB.
// Snapshots ROB tail/occupancy on every dispatched branch into a circular
// slot FIFO (program order), keeps each snapshot's occupancy current across
// commits, and on a mispredict drives a one-cycle ROB recover plus redirect.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous reset, active-high
//   bus    rob_branch_chkpt_ctrl_if.slave (dispatch, mispredict, commit,
//          ROB alloc/commit/recover, redirect, free-slot count, error flag)
module rob_branch_chkpt_ctrl #(
    parameter int DEPTH = 16,
    parameter int NCHK  = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    rob_branch_chkpt_ctrl_if.slave bus
);
    localparam int RW = $clog2(DEPTH);
    localparam int CW = $clog2(NCHK);

    typedef enum logic [1:0] {IDLE, RECOVER, SETTLE} state_t;

    state_t state_q, state_d;

    logic [NCHK-1:0]         slot_vld;
    logic [NCHK-1:0][RW-1:0] slot_idx;
    logic [NCHK-1:0][RW-1:0] slot_tail;
    logic [NCHK-1:0][RW:0]   slot_used;

    logic [CW-1:0] hptr, tptr, rec_slot, hit_slot;
    logic [CW:0]   cnt, keep_cnt;
    logic [31:0]   tgt;
    logic          err;
    logic          hit, alloc_ok, afire, awr, cfire, bcommit, mp_fire, recover;

    assign recover  = (state_q == RECOVER);
    assign alloc_ok = (state_q == IDLE) && !(bus.disp_is_branch_i && cnt == (CW+1)'(NCHK));
    assign afire    = bus.disp_valid_i && alloc_ok && bus.rob_alloc_ready_i;
    assign awr      = afire && bus.disp_is_branch_i;
    assign cfire    = bus.commit_valid_i && bus.commit_ready_i && !recover;
    assign bcommit  = cfire && bus.commit_is_branch_i;
    assign mp_fire  = (state_q == IDLE) && bus.mp_valid_i;

    // Slots kept after recovery: head through rec_slot inclusive.
    assign keep_cnt = {1'b0, rec_slot - hptr} + (CW+1)'(1);

    // CAM of the mispredict index against live slots.
    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (slot_vld[i] && slot_idx[i] == bus.mp_rob_index_i) begin
                hit      = 1'b1;
                hit_slot = CW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mp_fire && hit) state_d = RECOVER;
            RECOVER: state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            slot_vld  <= '0;
            slot_idx  <= '0;
            slot_tail <= '0;
            slot_used <= '0;
            hptr      <= '0;
            tptr      <= '0;
            cnt       <= '0;
            rec_slot  <= '0;
            tgt       <= '0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mp_fire && hit) begin
                rec_slot <= hit_slot;
                tgt      <= bus.mp_target_i;
            end
            if (mp_fire && !hit) err <= 1'b1;

            for (int i = 0; i < NCHK; i++) begin
                if (awr && tptr == CW'(i)) begin
                    // Snapshot is the ROB state right after the branch allocates.
                    slot_vld[i]  <= 1'b1;
                    slot_idx[i]  <= bus.rob_chkpt_tail_i;
                    slot_tail[i] <= bus.rob_chkpt_tail_i + RW'(1);
                    slot_used[i] <= bus.rob_chkpt_used_i + (RW+1)'(1) - (RW+1)'(cfire);
                end else if (recover) begin
                    // Drop slots younger than the mispredicted branch.
                    if ((CW'(i) - hptr) > (rec_slot - hptr)) slot_vld[i] <= 1'b0;
                end else begin
                    if (cfire && slot_vld[i]) slot_used[i] <= slot_used[i] - (RW+1)'(1);
                    if (bcommit && hptr == CW'(i)) slot_vld[i] <= 1'b0;
                end
            end

            if (recover) begin
                tptr <= rec_slot + CW'(1);
                cnt  <= keep_cnt;
            end else begin
                if (awr)     tptr <= tptr + CW'(1);
                if (bcommit) hptr <= hptr + CW'(1);
                cnt <= cnt + (CW+1)'(awr) - (CW+1)'(bcommit);
            end
        end
    end

    // A snapshot's occupancy can never be decremented below zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NCHK; i++) begin
                if (cfire && slot_vld[i] && !(awr && tptr == CW'(i)))
                    assert (slot_used[i] != '0);
            end
        end
    end

    assign bus.rob_alloc_valid_o  = bus.disp_valid_i && alloc_ok;
    assign bus.disp_ready_o       = alloc_ok && bus.rob_alloc_ready_i;
    assign bus.rob_commit_ready_o = bus.commit_ready_i && !recover;
    assign bus.mp_ready_o         = (state_q == IDLE);
    assign bus.rob_recover_o      = recover;
    assign bus.rob_recover_tail_o = recover ? slot_tail[rec_slot] : '0;
    assign bus.rob_recover_used_o = recover ? slot_used[rec_slot] : '0;
    assign bus.redirect_valid_o   = recover;
    assign bus.redirect_pc_o      = tgt;
    assign bus.chk_free_o         = (CW+1)'(NCHK) - cnt;
    assign bus.err_nomatch_o      = err;
endmodule
